// File: rtl/tabajara_pkg.sv
// Shared types and VGA timing constants for the game's shared-state logic.
package tabajara_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT
    } sched_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first set bit of eligible at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] j;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        sum    = '0;
        j      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            j = sum[IW-1:0];
            if (!valid && eligible[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants exclusive shared-state access to update engines, one at a time, during
// vertical blanking; round-robin, once per engine per frame, with a grant timeout.
module vblank_update_scheduler #(
    parameter int N_REQ       = 4,
    parameter int V_ACTIVE    = tabajara_pkg::V_ACTIVE,
    parameter int V_TOTAL     = tabajara_pkg::V_TOTAL,
    parameter int GUARD_LINES = 2,
    parameter int MAX_GRANT   = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               h_counter,
    input  logic [9:0]               v_counter,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     busy,
    output logic                     frame_tick,
    output logic                     overrun,
    output logic                     abort,
    output logic [N_REQ-1:0]         served,
    output logic [7:0]               frame_count
);
    import tabajara_pkg::*;

    localparam int IW = $clog2(N_REQ);
    localparam int GW = $clog2(MAX_GRANT);

    sched_state_t   state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [N_REQ-1:0] served_q, served_d;
    logic [7:0]     fc_q, fc_d;
    logic [GW-1:0]  gcnt_q, gcnt_d;
    logic           in_vb_q, in_vb_qq;
    logic           tick_q, tick_d;
    logic           ovr_q, ovr_d;
    logic           abort_q, abort_d;

    logic           in_vb, late, open_win;
    logic           pick_valid;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]  pick_idx;

    // Horizontal position is not needed for scheduling.
    logic unused_h;
    assign unused_h = ^h_counter;

    assign in_vb    = (v_counter >= 10'(V_ACTIVE));
    assign late     = (v_counter >= 10'(V_TOTAL - GUARD_LINES));
    assign open_win = in_vb_q & ~in_vb_qq;

    rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .eligible (req & ~served_q),
        .rr_ptr   (rr_q),
        .valid    (pick_valid),
        .onehot   (pick_oh),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        served_d = served_q;
        fc_d     = fc_q;
        gcnt_d   = gcnt_q;
        tick_d   = 1'b0;
        ovr_d    = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (open_win) begin
                    served_d = '0;
                    tick_d   = 1'b1;
                    fc_d     = fc_q + 8'd1;
                    state_d  = ARB;
                end
            end
            ARB: begin
                if (!in_vb) begin
                    state_d = IDLE;
                end else if (!late && pick_valid) begin
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    gcnt_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Window close beats a same-cycle done; done beats timeout.
                if (!in_vb) begin
                    grant_d = '0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (done[gidx_q] || gcnt_q == GW'(MAX_GRANT - 1)) begin
                    grant_d          = '0;
                    served_d[gidx_q] = 1'b1;
                    rr_d             = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
                    ovr_d            = ~done[gidx_q];
                    state_d          = ARB;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            served_q <= '0;
            fc_q     <= '0;
            gcnt_q   <= '0;
            in_vb_q  <= 1'b0;
            in_vb_qq <= 1'b0;
            tick_q   <= 1'b0;
            ovr_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            served_q <= served_d;
            fc_q     <= fc_d;
            gcnt_q   <= gcnt_d;
            in_vb_q  <= in_vb;
            in_vb_qq <= in_vb_q;
            tick_q   <= tick_d;
            ovr_q    <= ovr_d;
            abort_q  <= abort_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = gidx_q;
    assign busy        = (state_q != IDLE);
    assign frame_tick  = tick_q;
    assign overrun     = ovr_q;
    assign abort       = abort_q;
    assign served      = served_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Directed bench for vblank_update_scheduler (N_REQ=4, MAX_GRANT=16).
module tb_vblank_update_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h_counter, v_counter;
    logic [3:0] req, done;
    logic [3:0] grant, served;
    logic [1:0] grant_idx;
    logic       busy, frame_tick, overrun, abort;
    logic [7:0] frame_count;

    int errors = 0;
    int checks = 0;

    vblank_update_scheduler #(.N_REQ(4), .MAX_GRANT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .h_counter   (h_counter),
        .v_counter   (v_counter),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .frame_tick  (frame_tick),
        .overrun     (overrun),
        .abort       (abort),
        .served      (served),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame();
        v_counter = 10'd480; clk1();
        v_counter = 10'd481; clk1();
        v_counter = 10'd482; clk1();
    endtask

    task automatic close_frame();
        v_counter = 10'd0; clk1();
    endtask

    task automatic quick_frame();
        v_counter = 10'd480; clk1(); clk1();
        v_counter = 10'd0;   clk1();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, tick_v, gseen;
        reset = 1'b1; h_counter = '0; v_counter = '0; req = '0; done = '0;
        clk1(); clk1();
        reset = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_idx", grant_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_served", served, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_pulses", {frame_tick, overrun, abort}, 0);

        // Two idle frames swept line by line
        ticks = 0; tick_v = -1; gseen = 0;
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < 525; v++) begin
                v_counter = 10'(v);
                clk1();
                if (frame_tick) begin
                    ticks++;
                    if (f == 0) tick_v = v;
                end
                if (grant != 4'd0) gseen = 1;
            end
        chk("sweep_ticks", ticks, 2);
        chk("sweep_tick_line", tick_v, 481);
        chk("sweep_nogrant", gseen, 0);
        chk("sweep_fc", frame_count, 2);
        close_frame();
        chk("sweep_idle", busy, 0);

        // All four requesting, done 3 cycles after each grant
        req = 4'b1111;
        open_frame();
        chk("e2_grant", grant, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", grant, 32'(1 << k));
            chk("rr_idx", grant_idx, k);
            clk1(); clk1();
            done = 4'(1 << k);
            clk1();
            chk("rr_drop", grant, 0);
            done = '0;
            clk1();
        end
        chk("rr_served", served, 4'b1111);
        chk("rr_nogrant", grant, 0);
        chk("rr_fc", frame_count, 3);
        close_frame();
        open_frame();
        chk("rr_restart0", grant, 4'b0001);

        // Window closes under an active grant
        v_counter = 10'd524; clk1();
        chk("abort_hold", grant, 4'b0001);
        v_counter = 10'd0; clk1();
        chk("abort_pulse", abort, 1);
        chk("abort_grant", grant, 0);
        chk("abort_served", served, 0);
        chk("abort_busy", busy, 0);
        clk1();
        chk("abort_1cyc", abort, 0);
        open_frame();
        chk("reserve_grant", grant, 4'b0001);
        clk1(); clk1();
        done = 4'b0001; req = 4'b0000;
        clk1();
        done = '0;
        chk("reserve_served", served, 4'b0001);
        clk1();
        close_frame();

        // rr_ptr = 1, requests 0 and 2
        req = 4'b0101;
        open_frame();
        chk("rp_first", grant, 4'b0100);
        clk1(); clk1(); done = 4'b0100; clk1(); done = '0; clk1();
        chk("rp_second", grant, 4'b0001);
        chk("rp_second_idx", grant_idx, 0);
        clk1(); clk1(); done = 4'b0001; clk1(); done = '0;
        chk("rp_served", served, 4'b0101);
        clk1();
        close_frame();

        // Engine 1 never finishes; stray done and req drop are ignored
        req = 4'b0110;
        open_frame();
        chk("to_grant", grant, 4'b0010);
        req = 4'b0100; done = 4'b0001;
        clk1();
        done = '0;
        repeat (14) clk1();
        chk("to_hold15", grant, 4'b0010);
        chk("to_noovr", overrun, 0);
        clk1();
        chk("to_revoke", grant, 0);
        chk("to_overrun", overrun, 1);
        chk("to_served", served, 4'b0010);
        clk1();
        chk("to_next", grant, 4'b0100);
        chk("to_ovr_1cyc", overrun, 0);
        repeat (15) clk1();
        done = 4'b0100;
        clk1();
        done = '0;
        chk("dt_drop", grant, 0);
        chk("dt_noovr", overrun, 0);
        chk("dt_served", served, 4'b0110);
        clk1();
        close_frame();

        // Guard lines block new grants
        req = 4'b0000;
        v_counter = 10'd480; clk1();
        v_counter = 10'd481; clk1();
        v_counter = 10'd523; req = 4'b1000;
        clk1(); clk1(); clk1();
        chk("late_nogrant", grant, 0);
        chk("late_busy", busy, 1);
        v_counter = 10'd524; clk1();
        chk("late_nogrant524", grant, 0);
        close_frame();
        open_frame();
        chk("pre_rst_grant", grant, 4'b1000);
        chk("pre_rst_idx", grant_idx, 3);

        // Reset mid-grant, with blanking still active afterwards
        reset = 1'b1;
        clk1();
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_idx", grant_idx, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fc", frame_count, 0);
        chk("mid_rst_served", served, 0);
        reset = 1'b0;
        clk1(); clk1();
        chk("post_rst_tick", frame_tick, 1);
        chk("post_rst_fc", frame_count, 1);
        clk1();
        chk("post_rst_grant", grant, 4'b1000);

        // done and window close in the same cycle
        v_counter = 10'd0; done = 4'b1000;
        clk1();
        done = '0;
        chk("dc_abort", abort, 1);
        chk("dc_served", served, 0);
        chk("dc_grant", grant, 0);

        // frame_count wraps
        req = 4'b0000;
        repeat (254) quick_frame();
        chk("fc_255", frame_count, 255);
        quick_frame();
        chk("fc_wrap", frame_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
